// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store lane-alignment unit.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: access-size encodings, alignment FSM state type, size->byte-count helper.
package lsu_pkg;

  // Access size encodings as presented on req_size.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_t;

  // Number of bytes touched by an access of the given size (1, 2, 4 or 8).
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_lane_shift.sv
// Byte-lane shifter: places a right-aligned store into bus lanes for one beat of an access.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: offset/size describe the access, beat selects the first (0) or spill-over (1) bus word,
//        wdata is right-aligned store data; mask is the per-lane write mask, sdata the shifted data.
module lsu_lane_shift
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [OW-1:0]     offset,
  input  logic [1:0]        size,
  input  logic              beat,
  input  logic [DATA_W-1:0] wdata,
  output logic [NB-1:0]     mask,
  output logic [DATA_W-1:0] sdata
);

  logic [2*NB-1:0]     len_mask;
  logic [2*NB-1:0]     span;
  logic [2*DATA_W-1:0] wide;

  // Shift into a double-width window: the low half is the first bus word,
  // the high half is whatever spills into the following word.
  always_comb begin
    len_mask = ((2*NB)'(1) << size_bytes(size)) - (2*NB)'(1);
    span     = len_mask << offset;
    wide     = {{DATA_W{1'b0}}, wdata} << {offset, 3'b000};
    mask     = beat ? span[2*NB-1:NB] : span[NB-1:0];
    sdata    = beat ? wide[2*DATA_W-1:DATA_W] : wide[DATA_W-1:0];
  end

endmodule

// File: rtl/lsu_lane_align.sv
// Load/store alignment: turns right-aligned CPU accesses into word-aligned bus beats, splitting
// word-crossing accesses in two. Latency: bus from the cycle after accept; response the cycle after
// the final bus_ack (error response the cycle after accept). Backpressure: req_ready only while idle.
// Ports: CLK/RES clock and sync reset; req_* CPU request; rsp_* one-cycle response pulse;
//        bus_adr/bus_rd/bus_wren/bus_do beat request held until bus_ack; bus_di read data with bus_ack.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MISALIGNED = 1
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   bus_adr,
  output logic                bus_rd,
  output logic [DATA_W/8-1:0] bus_wren,
  output logic [DATA_W-1:0]   bus_do,
  input  logic [DATA_W-1:0]   bus_di,
  input  logic                bus_ack
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);

  state_t state, state_n;

  logic              accept;
  logic [OW-1:0]     req_off;
  logic [4:0]        req_end;
  logic              req_cross;
  logic              req_bad;

  logic [OW-1:0]     off_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              signed_q;
  logic              cross_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] di0_q;
  logic [ADDR_W-1:0] base_q;

  logic              busy;
  logic              beat1;
  logic [NB-1:0]     lane_mask;
  logic [DATA_W-1:0] lane_data;

  logic [DATA_W-1:0] ld_lo;
  logic [DATA_W-1:0] ld_hi;
  logic [DATA_W-1:0] ld_aligned;
  logic [DATA_W-1:0] ld_result;
  logic [3:0]        ld_len;
  logic              ld_sign;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign busy      = (state != ST_IDLE);
  assign beat1     = (state == ST_BEAT1);

  // Classify the request at accept time: does it spill into the next bus word, and is it legal.
  assign req_off   = req_addr[OW-1:0];
  assign req_end   = 5'(req_off) + 5'(size_bytes(req_size));
  assign req_cross = (req_end > 5'(NB));
  assign req_bad   = ((req_size == SZ_D) && (DATA_W == 32)) || (req_cross && (MISALIGNED == 0));

  // ---------------- FSM ----------------
  always_ff @(posedge CLK) begin
    if (RES) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (accept && !req_bad) state_n = ST_BEAT0;
      ST_BEAT0: if (bus_ack) state_n = cross_q ? ST_BEAT1 : ST_IDLE;
      ST_BEAT1: if (bus_ack) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // ---------------- store lane placement for the current beat ----------------
  lsu_lane_shift #(.DATA_W(DATA_W)) u_shift (
    .offset (off_q),
    .size   (size_q),
    .beat   (beat1),
    .wdata  (wdata_q),
    .mask   (lane_mask),
    .sdata  (lane_data)
  );

  // Bus outputs are functions of registered state only, so they are stable for the whole beat.
  assign bus_rd   = busy && !we_q;
  assign bus_wren = (busy && we_q) ? lane_mask : '0;
  assign bus_do   = (busy && we_q) ? lane_data : '0;
  assign bus_adr  = busy ? (beat1 ? base_q + ADDR_W'(NB) : base_q) : '0;

  // ---------------- load reassembly ----------------
  // On the final ack the two words are {bus_di, di0_q} for a split access, {0, bus_di} otherwise.
  always_comb begin
    ld_lo      = beat1 ? di0_q : bus_di;
    ld_hi      = beat1 ? bus_di : '0;
    ld_aligned = DATA_W'({ld_hi, ld_lo} >> {off_q, 3'b000});
    ld_len     = size_bytes(size_q);
    ld_sign    = 1'b0;
    case (size_q)
      SZ_B:    ld_sign = ld_aligned[7];
      SZ_H:    ld_sign = ld_aligned[15];
      SZ_W:    ld_sign = ld_aligned[31];
      default: ld_sign = ld_aligned[DATA_W-1];
    endcase
    ld_result = '0;
    for (int i = 0; i < NB; i++) begin
      ld_result[8*i +: 8] = (4'(i) < ld_len) ? ld_aligned[8*i +: 8] : {8{ld_sign && signed_q}};
    end
  end

  // ---------------- request capture and response ----------------
  always_ff @(posedge CLK) begin
    if (RES) begin
      off_q     <= '0;
      size_q    <= SZ_B;
      we_q      <= 1'b0;
      signed_q  <= 1'b0;
      cross_q   <= 1'b0;
      wdata_q   <= '0;
      di0_q     <= '0;
      base_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      if (accept) begin
        if (req_bad) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end else begin
          off_q    <= req_off;
          size_q   <= req_size;
          we_q     <= req_we;
          signed_q <= req_signed;
          cross_q  <= req_cross;
          wdata_q  <= req_wdata;
          base_q   <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
        end
      end
      if ((state == ST_BEAT0) && bus_ack) begin
        di0_q <= bus_di;
        if (!cross_q) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= we_q ? '0 : ld_result;
        end
      end
      if ((state == ST_BEAT1) && bus_ack) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= we_q ? '0 : ld_result;
      end
    end
  end

endmodule

// File: tb/tb_lsu_lane_align.sv
// Bench for lsu_lane_align: three instances (32-bit split, 32-bit no-split, 64-bit split).
// Latency: n/a. Backpressure: the bus model acks each beat in the cycle it is presented.
// Expected beats and responses are queued by the stimulus; one monitor process checks both sides.
module tb_lsu_lane_align;
  import lsu_pkg::*;

  typedef struct packed {
    logic [31:0] adr;
    logic        rd;
    logic [7:0]  wren;
    logic [63:0] dout;
    logic [63:0] di;
    logic        ack;
  } beat_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
    logic [31:0] cyc;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  int n_tests = 0;
  int n_fail  = 0;

  logic        res        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [1:0]  req_size   [3];
  logic        req_signed [3];
  logic [31:0] req_addr   [3];
  logic [63:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic [63:0] rsp_rdata  [3];
  logic        rsp_err    [3];
  logic [31:0] bus_adr    [3];
  logic        bus_rd     [3];
  logic [7:0]  bus_wren   [3];
  logic [63:0] bus_do     [3];
  logic [63:0] bus_di     [3];
  logic        bus_ack    [3];

  logic [31:0] rd32 [2];
  logic [3:0]  wr32 [2];
  logic [31:0] do32 [2];

  assign rsp_rdata[0] = {32'h0, rd32[0]};
  assign rsp_rdata[1] = {32'h0, rd32[1]};
  assign bus_wren[0]  = {4'h0, wr32[0]};
  assign bus_wren[1]  = {4'h0, wr32[1]};
  assign bus_do[0]    = {32'h0, do32[0]};
  assign bus_do[1]    = {32'h0, do32[1]};

  beat_t beat_q [3][$];
  rsp_t  rsp_q  [3][$];

  lsu_lane_align #(.DATA_W(32), .ADDR_W(32), .MISALIGNED(1)) u_mis (
    .CLK(clk), .RES(res[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0][31:0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rd32[0]), .rsp_err(rsp_err[0]), .bus_adr(bus_adr[0]), .bus_rd(bus_rd[0]),
    .bus_wren(wr32[0]), .bus_do(do32[0]), .bus_di(bus_di[0][31:0]), .bus_ack(bus_ack[0]));

  lsu_lane_align #(.DATA_W(32), .ADDR_W(32), .MISALIGNED(0)) u_strict (
    .CLK(clk), .RES(res[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1][31:0]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rd32[1]), .rsp_err(rsp_err[1]), .bus_adr(bus_adr[1]), .bus_rd(bus_rd[1]),
    .bus_wren(wr32[1]), .bus_do(do32[1]), .bus_di(bus_di[1][31:0]), .bus_ack(bus_ack[1]));

  lsu_lane_align #(.DATA_W(64), .ADDR_W(32), .MISALIGNED(1)) u_wide (
    .CLK(clk), .RES(res[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_size(req_size[2]), .req_signed(req_signed[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .bus_adr(bus_adr[2]), .bus_rd(bus_rd[2]),
    .bus_wren(bus_wren[2]), .bus_do(bus_do[2]), .bus_di(bus_di[2]), .bus_ack(bus_ack[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got an event, expected none", nm);
  endtask

  task automatic push_beat(input int k, input logic [31:0] adr, input logic rd, input logic [7:0] wren,
                           input logic [63:0] dout, input logic [63:0] di, input logic ack);
    beat_t b;
    b.adr = adr; b.rd = rd; b.wren = wren; b.dout = dout; b.di = di; b.ack = ack;
    beat_q[k].push_back(b);
  endtask

  // lat: expected cycles from accept to response; 0 means no response is expected.
  task automatic issue(input int k, input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] adr, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic exp_err, input int lat);
    rsp_t r;
    int   w;
    w = 0;
    @(negedge clk);
    while (!req_ready[k] && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready[k]) begin
      chk($sformatf("u%0d req_ready wait", k), 64'(req_ready[k]), 64'd1);
      return;
    end
    req_we[k] = we; req_size[k] = sz; req_signed[k] = sgn;
    req_addr[k] = adr; req_wdata[k] = wd; req_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    if (lat > 0) begin
      r.rdata = exp_rd;
      r.err   = exp_err;
      r.cyc   = cyc + 32'(lat) - 32'd1;
      rsp_q[k].push_back(r);
    end
  endtask

  // Monitor + zero-wait bus model for all three instances.
  initial begin
    rsp_t  r;
    beat_t b;
    logic  wait_idle [3];
    for (int k = 0; k < 3; k++) begin
      bus_ack[k] = 1'b0; bus_di[k] = '0; wait_idle[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rsp_valid[k]) begin
          if (rsp_q[k].size() == 0) flag($sformatf("u%0d unexpected rsp_valid", k));
          else begin
            r = rsp_q[k].pop_front();
            chk($sformatf("u%0d rsp_rdata", k), rsp_rdata[k], r.rdata);
            chk($sformatf("u%0d rsp_err", k), 64'(rsp_err[k]), 64'(r.err));
            chk($sformatf("u%0d rsp cycle", k), 64'(cyc), 64'(r.cyc));
          end
        end
        if (bus_rd[k] || bus_wren[k] != 8'h00) begin
          if (!wait_idle[k]) begin
            if (beat_q[k].size() == 0) begin
              flag($sformatf("u%0d unexpected bus beat adr=0x%0h", k, bus_adr[k]));
              bus_di[k] = '0; bus_ack[k] = 1'b1;
            end else begin
              b = beat_q[k].pop_front();
              chk($sformatf("u%0d bus_adr", k), 64'(bus_adr[k]), 64'(b.adr));
              chk($sformatf("u%0d bus_rd", k), 64'(bus_rd[k]), 64'(b.rd));
              chk($sformatf("u%0d bus_wren", k), 64'(bus_wren[k]), 64'(b.wren));
              if (!b.rd) chk($sformatf("u%0d bus_do", k), bus_do[k], b.dout);
              if (b.ack) begin
                bus_di[k] = b.di; bus_ack[k] = 1'b1;
              end else begin
                wait_idle[k] = 1'b1;
              end
            end
          end
        end else begin
          wait_idle[k] = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) bus_ack[k] = 1'b0;
    end
  end

  // Stimulus.
  initial begin
    for (int k = 0; k < 3; k++) begin
      res[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = SZ_B;
      req_signed[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d reset req_ready", k), 64'(req_ready[k]), 64'd1);
      chk($sformatf("u%0d reset rsp_valid", k), 64'(rsp_valid[k]), 64'd0);
      chk($sformatf("u%0d reset rsp_err", k), 64'(rsp_err[k]), 64'd0);
      chk($sformatf("u%0d reset rsp_rdata", k), rsp_rdata[k], 64'd0);
      chk($sformatf("u%0d reset bus_rd", k), 64'(bus_rd[k]), 64'd0);
      chk($sformatf("u%0d reset bus_wren", k), 64'(bus_wren[k]), 64'd0);
      chk($sformatf("u%0d reset bus_adr", k), 64'(bus_adr[k]), 64'd0);
      chk($sformatf("u%0d reset bus_do", k), bus_do[k], 64'd0);
      res[k] = 1'b0;
    end

    // ---- 32-bit, split allowed ----
    push_beat(0, 32'h0C, 1'b0, 8'h01, 64'h00000032, 64'h0, 1'b1);
    issue(0, 1'b1, SZ_B, 1'b0, 32'h0C, 64'h32, 64'h0, 1'b0, 2);
    push_beat(0, 32'h0C, 1'b0, 8'h02, 64'h00003100, 64'h0, 1'b1);
    issue(0, 1'b1, SZ_B, 1'b0, 32'h0D, 64'h31, 64'h0, 1'b0, 2);
    push_beat(0, 32'h0C, 1'b1, 8'h00, 64'h0, 64'h00003132, 1'b1);
    issue(0, 1'b0, SZ_B, 1'b0, 32'h0C, 64'h0, 64'h32, 1'b0, 2);
    push_beat(0, 32'h0C, 1'b1, 8'h00, 64'h0, 64'h00003132, 1'b1);
    issue(0, 1'b0, SZ_B, 1'b0, 32'h0D, 64'h0, 64'h31, 1'b0, 2);
    push_beat(0, 32'h0C, 1'b1, 8'h00, 64'h0, 64'h000000F0, 1'b1);
    issue(0, 1'b0, SZ_B, 1'b1, 32'h0C, 64'h0, 64'hFFFFFFF0, 1'b0, 2);
    push_beat(0, 32'h0C, 1'b0, 8'h0C, 64'hCCDD0000, 64'h0, 1'b1);
    push_beat(0, 32'h10, 1'b0, 8'h03, 64'h0000AABB, 64'h0, 1'b1);
    issue(0, 1'b1, SZ_W, 1'b0, 32'h0E, 64'hAABBCCDD, 64'h0, 1'b0, 3);
    push_beat(0, 32'h0C, 1'b1, 8'h00, 64'h0, 64'h12345678, 1'b1);
    push_beat(0, 32'h10, 1'b1, 8'h00, 64'h0, 64'h000000F5, 1'b1);
    issue(0, 1'b0, SZ_H, 1'b1, 32'h0F, 64'h0, 64'hFFFFF512, 1'b0, 3);
    push_beat(0, 32'h08, 1'b1, 8'h00, 64'h0, 64'h44332211, 1'b1);
    push_beat(0, 32'h0C, 1'b1, 8'h00, 64'h0, 64'h88776655, 1'b1);
    issue(0, 1'b0, SZ_W, 1'b0, 32'h0A, 64'h0, 64'h66554433, 1'b0, 3);
    push_beat(0, 32'h00, 1'b1, 8'h00, 64'h0, 64'hBEEF1234, 1'b1);
    issue(0, 1'b0, SZ_H, 1'b0, 32'h02, 64'h0, 64'h0000BEEF, 1'b0, 2);
    push_beat(0, 32'h00, 1'b1, 8'h00, 64'h0, 64'hBEEF1234, 1'b1);
    issue(0, 1'b0, SZ_H, 1'b1, 32'h02, 64'h0, 64'hFFFFBEEF, 1'b0, 2);
    push_beat(0, 32'h00, 1'b0, 8'h06, 64'h00123400, 64'h0, 1'b1);
    issue(0, 1'b1, SZ_H, 1'b0, 32'h01, 64'h1234, 64'h0, 1'b0, 2);
    issue(0, 1'b0, SZ_D, 1'b0, 32'h00, 64'h0, 64'h0, 1'b1, 1);

    // Reset while the second beat is waiting for an ack that never comes.
    push_beat(0, 32'h0C, 1'b0, 8'h08, 64'h44000000, 64'h0, 1'b1);
    push_beat(0, 32'h10, 1'b0, 8'h07, 64'h00112233, 64'h0, 1'b0);
    issue(0, 1'b1, SZ_W, 1'b0, 32'h0F, 64'h11223344, 64'h0, 1'b0, 0);
    begin
      int w;
      w = 0;
      @(negedge clk);
      while (bus_adr[0] != 32'h10 && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("u0 second beat presented", 64'(bus_adr[0]), 64'h10);
    end
    res[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("u0 abort req_ready", 64'(req_ready[0]), 64'd1);
    chk("u0 abort bus_rd", 64'(bus_rd[0]), 64'd0);
    chk("u0 abort bus_wren", 64'(bus_wren[0]), 64'd0);
    chk("u0 abort bus_adr", 64'(bus_adr[0]), 64'd0);
    chk("u0 abort bus_do", bus_do[0], 64'd0);
    chk("u0 abort rsp_valid", 64'(rsp_valid[0]), 64'd0);
    res[0] = 1'b0;
    push_beat(0, 32'h10, 1'b1, 8'h00, 64'h0, 64'hCAFEF00D, 1'b1);
    issue(0, 1'b0, SZ_W, 1'b0, 32'h10, 64'h0, 64'hCAFEF00D, 1'b0, 2);

    // ---- 32-bit, split disallowed ----
    issue(1, 1'b0, SZ_W, 1'b0, 32'h02, 64'h0, 64'h0, 1'b1, 1);
    issue(1, 1'b0, SZ_D, 1'b0, 32'h08, 64'h0, 64'h0, 1'b1, 1);
    issue(1, 1'b1, SZ_H, 1'b0, 32'h03, 64'hBEEF, 64'h0, 1'b1, 1);
    push_beat(1, 32'h04, 1'b1, 8'h00, 64'h0, 64'h01020304, 1'b1);
    issue(1, 1'b0, SZ_W, 1'b0, 32'h04, 64'h0, 64'h01020304, 1'b0, 2);
    push_beat(1, 32'h00, 1'b0, 8'h08, 64'h5A000000, 64'h0, 1'b1);
    issue(1, 1'b1, SZ_B, 1'b0, 32'h03, 64'h5A, 64'h0, 1'b0, 2);

    // ---- 64-bit, split allowed ----
    push_beat(2, 32'h08, 1'b0, 8'hFF, 64'h0123456789ABCDEF, 64'h0, 1'b1);
    issue(2, 1'b1, SZ_D, 1'b0, 32'h08, 64'h0123456789ABCDEF, 64'h0, 1'b0, 2);
    push_beat(2, 32'hFFFFFFF8, 1'b1, 8'h00, 64'h0, 64'hAB00000000000000, 1'b1);
    push_beat(2, 32'h00000000, 1'b1, 8'h00, 64'h0, 64'h00000000000000CD, 1'b1);
    issue(2, 1'b0, SZ_H, 1'b1, 32'hFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFCDAB, 1'b0, 3);
    push_beat(2, 32'h08, 1'b1, 8'h00, 64'h0, 64'h8765432100000000, 1'b1);
    issue(2, 1'b0, SZ_W, 1'b1, 32'h0C, 64'h0, 64'hFFFFFFFF87654321, 1'b0, 2);
    push_beat(2, 32'h00, 1'b0, 8'hC0, 64'hBEEF000000000000, 64'h0, 1'b1);
    push_beat(2, 32'h08, 1'b0, 8'h03, 64'h000000000000DEAD, 64'h0, 1'b1);
    issue(2, 1'b1, SZ_W, 1'b0, 32'h06, 64'hDEADBEEF, 64'h0, 1'b0, 3);

    // Drain, then make sure nothing expected was left outstanding.
    begin
      int w;
      w = 0;
      while (w < 200 && (rsp_q[0].size() + rsp_q[1].size() + rsp_q[2].size()
                         + beat_q[0].size() + beat_q[1].size() + beat_q[2].size()) != 0) begin
        @(posedge clk);
        w++;
      end
    end
    repeat (4) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d responses outstanding", k), 64'(rsp_q[k].size()), 64'd0);
      chk($sformatf("u%0d beats outstanding", k), 64'(beat_q[k].size()), 64'd0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_lane_align.md
# lsu_lane_align

Byte-lane load/store alignment unit between the darkriscv core's data port and the SoC memory bus. Converts right-aligned CPU accesses of 1, 2, 4 (or 8) bytes at arbitrary addresses into bus-word-aligned transactions with per-byte write masks. Misaligned accesses that cross a bus word are split into two bus beats. Load data is re-assembled and zero- or sign-extended. Generalises the fixed 32-bit per-byte mask path to a parametrised bus width with split-access support.

## Interface
- DATA_W, 32 — bus data width; 32 or 64; NB = DATA_W/8 byte lanes
- ADDR_W, 32 — byte address width
- MISALIGNED, 1 — 1: split crossing accesses into two beats; 0: crossing access returns error, no bus beat

- CLK  in  1  — single clock, all logic on rising edge
- RES  in  1  — synchronous, active-high reset
- req_valid  in  1  — CPU request present
- req_ready  out  1  — unit idle, accepts request
- req_we  in  1  — 1 store, 0 load
- req_size  in  2  — 0 byte, 1 half, 2 word, 3 dword (legal only if DATA_W=64)
- req_signed  in  1  — sign-extend load result
- req_addr  in  ADDR_W  — byte address
- req_wdata  in  DATA_W  — store data, right-aligned
- rsp_valid  out  1  — one-cycle response pulse
- rsp_rdata  out  DATA_W  — load result, right-aligned and extended; 0 for stores
- rsp_err  out  1  — illegal size or disallowed misalignment; valid with rsp_valid
- bus_adr  out  ADDR_W  — word-aligned address (low log2(NB) bits 0)
- bus_rd  out  1  — read beat active
- bus_wren  out  NB  — byte write mask; 0 during reads
- bus_do  out  DATA_W  — lane-shifted store data
- bus_di  in  DATA_W  — read data, valid with bus_ack
- bus_ack  in  1  — beat complete

## Operation
- States: IDLE, BEAT0, BEAT1. req_ready = (state==IDLE).
- Accept when req_valid & req_ready. Offset o = addr mod NB, length L = 1<<size.
- Error if size=3 and DATA_W=32, or o+L>NB with MISALIGNED=0: stay IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0 next cycle; no bus activity.
- Otherwise → BEAT0: bus_adr = addr & ~(NB-1), mask = ((1<<L)-1)<<o truncated to NB bits, bus_do = wdata<<(8·o).
- On bus_ack in BEAT0: if o+L>NB → BEAT1 with bus_adr+NB (wraps modulo 2^ADDR_W), mask = (1<<(o+L-NB))-1, bus_do = wdata>>(8·(NB-o)); else → IDLE.
- On bus_ack in BEAT1 → IDLE.
- Loads capture bus_di per beat; result = ({di1,di0} >> 8·o) masked to L bytes, sign bit = byte L-1 bit 7 when req_signed.
- bus_rd/bus_wren held stable for the whole beat until bus_ack; bus_ack outside BEAT0/BEAT1 ignored.
- RES in any state: → IDLE, beat aborted, no response for the aborted request.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_err 0, rsp_rdata 0, bus_rd 0, bus_wren 0, bus_adr 0, bus_do 0.
- Accept at edge T → bus signals driven (registered) from T+1.
- Final bus_ack sampled at edge T+k → rsp_valid pulse during cycle T+k+1, same cycle req_ready=1; a new request may be accepted in that cycle.
- Zero-wait bus (ack in first beat cycle): aligned access 2 cycles accept-to-response, split access 3 cycles.
- Error response: rsp_valid in cycle T+1.

## Structure
- Package lsu_pkg: size encodings SZ_B/SZ_H/SZ_W/SZ_D, state enum, helper function for size→byte count.
- Sub-module lsu_lane_shift (combinational): from offset, size, beat index, DATA_W → byte mask, shifted store data; instanced once, driven by current beat.

## Test plan
- DATA_W=32, sb 0x32 @0x0C then sb 0x31 @0x0D → bus_wren 4'b0001 adr 0x0C do 0x00000032; then 4'b0010 adr 0x0C do 0x00003100.
- lbu @0x0C, lbu @0x0D with bus_di 0x00003132 → rsp_rdata 0x32 then 0x31; lb @0x0C with di 0x000000F0 signed → 0xFFFFFFF0.
- sw 0xAABBCCDD @0x0E → beat0 adr 0x0C mask 1100 do 0xCCDD0000; beat1 adr 0x10 mask 0011 do 0x0000AABB; one rsp_valid.
- MISALIGNED=0, lw @0x02 → rsp_err=1 next cycle, bus_rd/bus_wren never asserted; DATA_W=32 size 3 → rsp_err=1.
- DATA_W=64, sd @0x08 → mask 8'hFF single beat; lh @0xFFFFFFFF → beats at 0xFFFFFFF8 and 0x00000000.
- RES asserted during BEAT1 with bus_ack held low → next cycle IDLE, bus signals 0, no rsp_valid.
